mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the processor's address register (AR) and data path.
- Accepts a single-word read or write request at the address the AR presents, then inserts a configurable number of wait states.
- Returns a one-cycle ack pulse; read data is valid with that pulse.
- Address VEC_ADDR (the reserved address the AR loads for vectoring) maps to an internal vector register, not the RAM array.

Parameters:
- AW, 12, address width (matches AR output width).
- DW, 16, data word width.
- WAIT_CYC, 2, wait states inserted between request acceptance and access (0..15).
- VEC_ADDR, 12'hFFE, reserved address mapped to the vector register.
- VEC_INIT, 16'h0000, reset value of the vector register.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- addr  in  AW  request address, driven by the AR data_out.
- wdata  in  DW  write data.
- rd_req  in  1  read request, sampled only when busy=0.
- wr_req  in  1  write request, sampled only when busy=0.
- rdata  out  DW  read data, valid while ack=1.
- ack  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with ack when the request was illegal.
- busy  out  1  high from the cycle after acceptance through the ack cycle.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM returns to IDLE and all counters clear.
  - rdata=0, ack=0, err=0, busy=0.
  - Vector register = VEC_INIT.
  - RAM contents are not reset.
  - Reset mid-operation aborts the transaction: no write is performed and no ack is issued.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - If (rd_req|wr_req) at a clk edge, latch addr, wdata and the op bits; set busy=1.
  - Next state is WAIT if WAIT_CYC>0, else ACCESS.
  - The wait counter loads WAIT_CYC-1.
- WAIT: decrement the counter each cycle; at 0, go to ACCESS.
- ACCESS (one cycle):
  - Both op bits set: no RAM or vector access; flag err.
  - Read: rdata_next = (addr==VEC_ADDR) ? vec_reg : ram[addr].
  - Write: the target (vec_reg or ram[addr]) is updated with wdata; rdata_next = wdata (echo).
  - Next state is RESP.
- RESP:
  - ack=1 for exactly one cycle; err=1 if flagged; rdata holds the value.
  - Next state is IDLE; busy drops after this cycle.
- rdata holds its last value after ack until the next RESP. ack and err are 0 outside RESP.
- Latency: a request sampled at edge N gives ack high in the cycle after edge N+2+WAIT_CYC. Each transaction takes 3+WAIT_CYC cycles plus 1 IDLE cycle before the next request can be sampled.
- Requests asserted while busy=1 are ignored, not queued. The requester must hold rd_req/wr_req until it sees busy or ack.
- Address wrap: addr is used as-is. All 2^AW locations exist. ram[VEC_ADDR] is shadowed and never accessed.
- The RAM array is DW x 2^AW, with a synchronous write and a registered read in ACCESS.

Decomposition:
- Shared package mem_pkg: state encoding constants (IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2, RESP=2'd3), VEC_ADDR, and the default AW/DW.
- One natural sub-module: mem_array. It is a single-port synchronous RAM (clk, we, addr, din, dout) and has no reset.
- The FSM, wait counter and vector register stay in the top module.

Test Plan:
- Reset: with rst_n=0 for 2 cycles, then release → ack=0, busy=0, rdata=0. A read of 12'hFFE returns 16'h0000 with ack at cycle 5 after the request edge (WAIT_CYC=2).
- Write then read: write 16'hBEEF to 12'h010, wait for ack, then read 12'h010 → rdata=16'hBEEF on the ack cycle, err=0. Latency between request edge and ack is exactly 5 cycles.
- Vector register: write 16'h0123 to 12'hFFE, then read 12'hFFE → 16'h0123. Read 12'h000 (never written) is unaffected by the vector write. Reset restores the vector register to 16'h0000.
- Illegal request: rd_req=wr_req=1 at 12'h020, where 12'h020 previously held 16'h5555 → ack=1 and err=1 in the same cycle. A subsequent read of 12'h020 returns 16'h5555.
- Busy collision and reset abort:
  - A second read is pulsed one cycle after acceptance → ignored; exactly one ack is seen.
  - A write of 16'hAAAA to 12'h030 is started, and rst_n=0 is asserted in WAIT → no ack. A read of 12'h030 after reset returns the prior contents.
- WAIT_CYC=0 build: read 12'hFFF → ack 3 cycles after the request edge. Back-to-back requests are accepted every 4 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding and default geometry.
package mem_pkg;
  localparam int MEM_AW = 12;
  localparam int MEM_DW = 16;
  localparam logic [MEM_AW-1:0] MEM_VEC_ADDR = 12'hFFE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered read. Contents survive reset.
module mem_array #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: single-word read/write with programmable wait states,
// one-cycle ack, and a vector register shadowing one reserved address.
module mem_responder
  import mem_pkg::*;
#(
  parameter int              AW       = MEM_AW,
  parameter int              DW       = MEM_DW,
  parameter int              WAIT_CYC = 2,
  parameter logic [AW-1:0]   VEC_ADDR = MEM_VEC_ADDR,
  parameter logic [DW-1:0]   VEC_INIT = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          rd_req,
  input  logic          wr_req,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          err,
  output logic          busy
);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [DW-1:0] vec_q, vec_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ack_q, ack_d, err_q, err_d, busy_q, busy_d;
  logic          ram_we;
  logic [DW-1:0] ram_dout;
  logic          vec_hit, illegal;

  assign vec_hit = (addr_q == VEC_ADDR);
  assign illegal = rd_q & wr_q;

  mem_array #(.AW(AW), .DW(DW)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr_q),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    vec_d   = vec_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // busy_q still covers the ack cycle, which keeps one idle cycle between transactions
        if (!busy_q && (rd_req || wr_req)) begin
          addr_d  = addr;
          wdata_d = wdata;
          rd_d    = rd_req;
          wr_d    = wr_req;
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_CYC > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: begin
        if (wr_q && !illegal) begin
          if (vec_hit) vec_d  = wdata_q;
          else         ram_we = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        // Outputs are registered, so ack/err/rdata appear in the cycle after RESP
        ack_d = 1'b1;
        err_d = illegal;
        if (!illegal) rdata_d = wr_q ? wdata_q : (vec_hit ? vec_q : ram_dout);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || ack_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      vec_q   <= VEC_INIT;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      vec_q   <= vec_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;
endmodule
